// File: rtl/disp_sched.sv
// disp_sched: display source scheduler for a seven-segment driver.
// Rotates between answer/pc/inst words automatically (every DWELL cycles)
// or manually via a debounced push button, and freezes while the CPU stalls.
// Optional macro DISP_SCHED_DEBOUNCE_EN: when defined, the button passes
// through a DEB-cycle debouncer; when undefined, the synchronized level is used directly.
module disp_sched #(
    parameter int unsigned DWELL = 50000000,
    parameter int unsigned DEB   = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        auto_en,
    input  logic        btn_next,
    input  logic [31:0] answer,
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    output logic [31:0] disp_data,
    output logic [1:0]  src_sel,
    output logic        sw_pulse
);

    typedef enum logic [1:0] {AUTO, MANUAL, FREEZE} state_t;

    state_t      state, state_nxt;
    logic        sync1, sync2;
    logic        btn_lvl, btn_lvl_q, press;
    logic [31:0] dwell_cnt, dwell_nxt, cnt_base;
    logic [1:0]  src_nxt;
    logic [31:0] data_nxt;
    logic        pulse_nxt, advance;

    if (DWELL < 1 || DEB < 1) begin : g_param_check
        $error("disp_sched: DWELL and DEB must be at least 1");
    end

    // Two-flop synchronizer for the asynchronous push button
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_next;
            sync2 <= sync1;
        end
    end

`ifdef DISP_SCHED_DEBOUNCE_EN
    logic [31:0] deb_cnt;

    // Accept a level change only after DEB consecutive differing cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_cnt <= '0;
            btn_lvl <= 1'b0;
        end else if (sync2 != btn_lvl) begin
            if (deb_cnt == DEB - 1) begin
                deb_cnt <= '0;
                btn_lvl <= sync2;
            end else begin
                deb_cnt <= deb_cnt + 32'd1;
            end
        end else begin
            deb_cnt <= '0;
        end
    end
`else
    assign btn_lvl = sync2;
`endif

    // Edge register: press is a one-cycle pulse on each rising button level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) btn_lvl_q <= 1'b0;
        else      btn_lvl_q <= btn_lvl;
    end

    assign press = btn_lvl & ~btn_lvl_q;

    // Mode state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= AUTO;
        else      state <= state_nxt;
    end

    // Next mode, dwell counting, source advance and display word selection.
    // Actions follow the mode chosen this cycle so stall takes effect at once
    // and leaving FREEZE loses no cycle.
    always_comb begin
        state_nxt = stall ? FREEZE : (auto_en ? AUTO : MANUAL);
        dwell_nxt = dwell_cnt;
        src_nxt   = src_sel;
        data_nxt  = disp_data;
        pulse_nxt = 1'b0;
        advance   = 1'b0;
        cnt_base  = dwell_cnt;
        case (state_nxt)
            AUTO: begin
                cnt_base  = (state == MANUAL) ? '0 : dwell_cnt;
                advance   = press | (cnt_base == DWELL - 1);
                dwell_nxt = advance ? '0 : cnt_base + 32'd1;
            end
            MANUAL: begin
                dwell_nxt = '0;
                advance   = press;
            end
            default: ;
        endcase
        if (advance) begin
            src_nxt   = (src_sel == 2'd2) ? 2'd0 : src_sel + 2'd1;
            pulse_nxt = 1'b1;
        end
        if (state_nxt != FREEZE) begin
            case (src_sel)
                2'd0:    data_nxt = answer;
                2'd1:    data_nxt = pc;
                2'd2:    data_nxt = inst;
                default: data_nxt = '0;
            endcase
        end
    end

    // Output and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dwell_cnt <= '0;
            src_sel   <= 2'd0;
            disp_data <= '0;
            sw_pulse  <= 1'b0;
        end else begin
            dwell_cnt <= dwell_nxt;
            src_sel   <= src_nxt;
            disp_data <= data_nxt;
            sw_pulse  <= pulse_nxt;
        end
    end

endmodule
